// File: rtl/pipeline_pkg.sv
// Shared pipeline constants and types used by fetch and decode.
package pipeline_pkg;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned INSTR_W = 16;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;
  localparam logic [3:0]         HALT_OP   = 4'hF;

  localparam int unsigned OPC_HI = 15;
  localparam int unsigned OPC_LO = 12;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_e;

  function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[OPC_HI:OPC_LO];
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load, hold or flush to a bubble, with a valid bit.
module if_id_reg
  import pipeline_pkg::*;
#(
  parameter int unsigned ADDR_W  = pipeline_pkg::ADDR_W,
  parameter int unsigned INSTR_W = pipeline_pkg::INSTR_W
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_flush,
  input  logic               i_load,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [ADDR_W-1:0]  i_pc_plus2,
  output logic [INSTR_W-1:0] o_instr,
  output logic [ADDR_W-1:0]  o_pc_plus2,
  output logic               o_valid
);

  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_pc_plus2;
  logic               r_valid;

  // Flush leaves pc_plus2 untouched; it is meaningless while valid is low.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_instr    <= '0;
      r_pc_plus2 <= '0;
      r_valid    <= 1'b0;
    end else if (i_flush) begin
      r_instr    <= INSTR_W'(NOP_INSTR);
      r_valid    <= 1'b0;
    end else if (i_load) begin
      r_instr    <= i_instr;
      r_pc_plus2 <= i_pc_plus2;
      r_valid    <= 1'b1;
    end
  end

  assign o_instr    = r_instr;
  assign o_pc_plus2 = r_pc_plus2;
  assign o_valid    = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, next-PC selection and the RUN/HALTED fetch FSM.
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned       ADDR_W   = pipeline_pkg::ADDR_W,
  parameter int unsigned       INSTR_W  = pipeline_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [3:0]        HALT_OP  = pipeline_pkg::HALT_OP
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc_plus2,
  output logic               if_id_valid,
  output logic               halted
);

  fetch_state_e      r_state, w_next_state;
  logic [ADDR_W-1:0] r_pc, w_next_pc, w_pc_plus2;
  logic              w_load, w_flush;

  assign w_pc_plus2 = r_pc + ADDR_W'(2);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_RUN;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
    end
  end

  // Priority: branch redirect > stall > normal fetch.
  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_load       = 1'b0;
    w_flush      = 1'b0;
    if (branch_taken) begin
      w_next_pc    = {branch_target[ADDR_W-1:1], 1'b0};
      w_flush      = 1'b1;
      w_next_state = ST_RUN;
    end else if (!stall) begin
      case (r_state)
        ST_RUN: begin
          w_load = 1'b1;
          if (imem_instr[INSTR_W-1 -: 4] == HALT_OP) begin
            w_next_state = ST_HALTED;
          end else begin
            w_next_pc = w_pc_plus2;
          end
        end
        ST_HALTED: w_flush = 1'b1;
        default:   w_next_state = ST_RUN;
      endcase
    end
  end

  if_id_reg #(
    .ADDR_W (ADDR_W),
    .INSTR_W(INSTR_W)
  ) u_if_id (
    .i_clk     (clk),
    .i_rst_n   (rst),
    .i_flush   (w_flush),
    .i_load    (w_load),
    .i_instr   (imem_instr),
    .i_pc_plus2(w_pc_plus2),
    .o_instr   (if_id_instr),
    .o_pc_plus2(if_id_pc_plus2),
    .o_valid   (if_id_valid)
  );

  assign pc     = r_pc;
  assign halted = (r_state == ST_HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed and randomized bench for fetch_stage against a cycle-level reference model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_target = '0;
  logic [15:0] imem_instr;
  logic [15:0] pc;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc_plus2;
  logic        if_id_valid;
  logic        halted;

  logic [7:0] mem [0:65535];

  int checks = 0;
  int errors = 0;

  logic [15:0] m_pc, m_instr, m_pc2;
  logic        m_valid, m_halted;

  always #5 clk = ~clk;

  // Big-endian instruction memory with combinational read at pc.
  assign imem_instr = {mem[pc], mem[pc + 16'd1]};

  fetch_stage #(
    .ADDR_W  (16),
    .INSTR_W (16),
    .RESET_PC(16'h0000),
    .HALT_OP (4'hF)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_instr    (imem_instr),
    .pc            (pc),
    .if_id_instr   (if_id_instr),
    .if_id_pc_plus2(if_id_pc_plus2),
    .if_id_valid   (if_id_valid),
    .halted        (halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advances the model by one edge from the spec rules, then compares the DUT.
  task automatic step(input logic r, input logic s, input logic b, input logic [15:0] t);
    logic [15:0] word;
    rst = r; stall = s; branch_taken = b; branch_target = t;
    word = {mem[m_pc], mem[m_pc + 16'd1]};
    if (!r) begin
      m_pc = 16'h0000; m_instr = 16'h0000; m_pc2 = 16'h0000; m_valid = 1'b0; m_halted = 1'b0;
    end else if (b) begin
      m_pc = t & 16'hFFFE; m_instr = 16'h0000; m_valid = 1'b0; m_halted = 1'b0;
    end else if (s) begin
      // everything holds
    end else if (!m_halted) begin
      m_instr = word; m_pc2 = m_pc + 16'd2; m_valid = 1'b1;
      if (word[15:12] == 4'hF) m_halted = 1'b1;
      else m_pc = m_pc + 16'd2;
    end else begin
      m_instr = 16'h0000; m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("pc", 32'(pc), 32'(m_pc));
    chk("if_id_valid", 32'(if_id_valid), 32'(m_valid));
    chk("if_id_instr", 32'(if_id_instr), 32'(m_instr));
    chk("halted", 32'(halted), 32'(m_halted));
    if (m_valid || !r) chk("if_id_pc_plus2", 32'(if_id_pc_plus2), 32'(m_pc2));
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h10; mem[1] = 8'h10; mem[2] = 8'h60; mem[3] = 8'h02;
    mem[4] = 8'hD0; mem[5] = 8'h04; mem[6] = 8'h10; mem[7] = 8'h11;
    mem[8] = 8'hF0; mem[9] = 8'h00;
    mem[14] = 8'h20; mem[15] = 8'h00;
    mem[16'hFFFE] = 8'h30; mem[16'hFFFF] = 8'h00;

    // Reset
    step(1'b0, 1'b0, 1'b0, 16'h0);
    chk("reset_pc", 32'(pc), 32'h0);
    chk("reset_valid", 32'(if_id_valid), 32'h0);

    // Straight-line fetch
    step(1'b1, 1'b0, 1'b0, 16'h0);
    chk("seq_pc2", 32'(pc), 32'h2);
    chk("seq_instr0", 32'(if_id_instr), 32'h1010);
    chk("seq_pcp2_0", 32'(if_id_pc_plus2), 32'h2);
    chk("seq_valid0", 32'(if_id_valid), 32'h1);
    step(1'b1, 1'b0, 1'b0, 16'h0);
    chk("seq_instr1", 32'(if_id_instr), 32'h6002);
    chk("seq_pc4", 32'(pc), 32'h4);

    // Stall two cycles at pc=4
    step(1'b1, 1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b1, 1'b0, 16'h0);
    chk("stall_pc", 32'(pc), 32'h4);
    chk("stall_instr", 32'(if_id_instr), 32'h6002);
    step(1'b1, 1'b0, 1'b0, 16'h0);
    chk("post_stall_instr", 32'(if_id_instr), 32'hD004);
    chk("post_stall_pc", 32'(pc), 32'h6);

    // Branch wins over stall
    step(1'b1, 1'b1, 1'b1, 16'h000E);
    chk("br_pc", 32'(pc), 32'hE);
    chk("br_bubble", 32'(if_id_valid), 32'h0);
    step(1'b1, 1'b0, 1'b0, 16'h0);
    chk("br_fetch", 32'(if_id_instr), 32'h2000);
    chk("br_fetch_pcp2", 32'(if_id_pc_plus2), 32'h10);

    // Odd target forced even
    step(1'b1, 1'b0, 1'b1, 16'h0007);
    chk("odd_target", 32'(pc), 32'h6);

    // HALT
    step(1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 16'h0);
    chk("halt_instr", 32'(if_id_instr), 32'hF000);
    chk("halt_valid", 32'(if_id_valid), 32'h1);
    chk("halt_flag", 32'(halted), 32'h1);
    chk("halt_pc", 32'(pc), 32'h8);
    step(1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 16'h0);
    chk("halted_bubble", 32'(if_id_valid), 32'h0);
    chk("halted_pc", 32'(pc), 32'h8);
    step(1'b1, 1'b0, 1'b1, 16'h0000);
    chk("unhalt", 32'(halted), 32'h0);
    chk("unhalt_pc", 32'(pc), 32'h0);
    step(1'b1, 1'b0, 1'b0, 16'h0);
    chk("resume_instr", 32'(if_id_instr), 32'h1010);

    // PC wraparound
    step(1'b1, 1'b0, 1'b1, 16'hFFFE);
    step(1'b1, 1'b0, 1'b0, 16'h0);
    chk("wrap_pc", 32'(pc), 32'h0);
    chk("wrap_pcp2", 32'(if_id_pc_plus2), 32'h0);

    // Mid-stream reset
    step(1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 16'h0);
    chk("pre_rst_pc", 32'(pc), 32'h6);
    step(1'b0, 1'b0, 1'b0, 16'h0);
    chk("mid_rst_pc", 32'(pc), 32'h0);
    chk("mid_rst_valid", 32'(if_id_valid), 32'h0);
    chk("mid_rst_halted", 32'(halted), 32'h0);
    step(1'b1, 1'b0, 1'b0, 16'h0);
    chk("post_rst_instr", 32'(if_id_instr), 32'h1010);

    // Randomized phase
    for (int n = 0; n < 400; n++) begin
      logic r, s, b;
      logic [15:0] t;
      r = ($urandom_range(0, 99) >= 2);
      s = ($urandom_range(0, 99) < 25);
      b = ($urandom_range(0, 99) < 10);
      t = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 63));
      step(r, s, b, t);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
IF stage of the 5-stage pipeline. It owns the program counter and drives the instruction memory read address. It captures the returned 16-bit instruction into the IF/ID pipeline register and handles stall, taken-branch redirect/flush and a HALT opcode. Upstream of decode; its PC feeds the instruction memory combinationally, and it consumes that memory's instruction in the same cycle.

Parameters:
ADDR_W, 16, PC / read-address width
INSTR_W, 16, instruction width (2 bytes, big-endian in memory)
RESET_PC, 16'h0000, PC value loaded on reset
HALT_OP, 4'hF, opcode (instr[15:12]) that stops fetch

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-low reset
stall  in  1  hazard unit: hold PC and IF/ID contents
branch_taken  in  1  EX-stage taken branch/jump: redirect and flush
branch_target  in  ADDR_W  redirect address
imem_instr  in  INSTR_W  instruction read at pc (combinational return)
pc  out  ADDR_W  current PC = instruction memory read address
if_id_instr  out  INSTR_W  IF/ID instruction
if_id_pc_plus2  out  ADDR_W  IF/ID PC+2 (branch base for decode/EX)
if_id_valid  out  1  IF/ID holds a real instruction (0 = bubble)
halted  out  1  fetch stopped by HALT

Behaviour:
- Reset (rst==0 at posedge) wins over everything. pc=RESET_PC, if_id_instr=16'h0000, if_id_pc_plus2=0, if_id_valid=0, halted=0, state=RUN.
- Reset is asserted mid-run: all in-flight IF/ID content is discarded the same edge.
- State machine: RUN, HALTED.
- Per-edge priority when not in reset: branch_taken > stall > normal fetch.
- branch_taken=1 (any state):
  - pc <= {branch_target[ADDR_W-1:1],1'b0}. Odd targets are forced even.
  - if_id_valid <= 0 and if_id_instr <= 0 (bubble).
  - state <= RUN and halted <= 0, because a HALT that was fetched is wrong-path.
  - Stall is ignored in this cycle.
- stall=1, no branch: pc and all IF/ID regs hold their values. State holds.
- RUN, normal fetch:
  - if_id_instr <= imem_instr, if_id_pc_plus2 <= pc+2, if_id_valid <= 1.
  - If imem_instr[15:12]==HALT_OP: pc holds, state <= HALTED, halted <= 1. The HALT instruction itself enters IF/ID valid.
  - Else pc <= pc+2.
- HALTED, normal: pc holds. if_id_valid <= 0 and if_id_instr <= 0, so bubbles are issued from the next cycle on. Only branch_taken or reset exits.
- Arithmetic: pc+2 is modulo 2^ADDR_W (16'hFFFE -> 16'h0000). No overflow flag.
- Latency: instruction at address A appears in IF/ID one edge after pc==A with no stall.
- Decode sees the taken-branch penalty as exactly one bubble.
- Outputs are registered. pc is the only value driven combinationally to the memory, and it comes straight from the register.

Decomposition:
- Shared package (pipeline_pkg): ADDR_W, INSTR_W, NOP_INSTR=16'h0000, HALT_OP, opcode field slice constants. Decode reuses these.
- Natural sub-module: if_id_reg, the IF/ID pipeline register with load/hold/flush controls and a valid bit. fetch_stage keeps the PC, next-PC mux and RUN/HALTED FSM.

Test Plan:
- Bench memory holds bytes 10 10 60 02 D0 04 10 11 at addresses 0-7.
  - Release reset, no stall -> pc 0,2,4,6,8.
  - IF/ID sequence: 1010/pc+2=2, 6002/4, D004/6, 1011/8. Valid is 1 from the first post-reset edge.
- stall=1 for 2 cycles while pc=4 -> pc stays 4 and if_id_instr stays 6002 for both cycles. Next edge loads D004, pc=6.
- branch_taken=1, target=16'h000E, together with stall=1 at pc=6 -> pc=E next edge, if_id_valid=0. The following edge fetches from E.
- branch_target=16'h0007 -> pc=6 (bit0 cleared).
- Memory word F000 at address 8:
  - After fetching it: if_id_instr=F000 valid, halted=1, pc stays 8. Later cycles give if_id_valid=0.
  - branch_taken=1, target=0 -> halted=0, pc=0, fetch resumes.
- Force pc=FFFE via branch, no stall -> next pc=0000, if_id_pc_plus2=0000.
- rst=0 for one edge mid-stream (pc=6, IF/ID valid) -> pc=0, if_id_valid=0, halted=0 at that edge. Normal fetch resumes after rst=1.
